lsu_wb: RTL and testbench
=========================

// Module: lsu_wb
// PURPOSE
//  Load/store + writeback stage of the rv64imac core; the write side of the GPR port.
//  - Accepts one op at a time from EXU and runs loads/stores on a single-outstanding dmem bus.
//  - Aligns and sign-extends load data.
//  - Drives the registered LS_WB_reg_* bundle and write_data that the GPR consumes.
//  - Detects misalignment and bus errors and reports them as traps.
// PARAMETERS
//  none (XLEN fixed at 64, dmem bus 64-bit, 8 byte lanes)
// PORTS
//  clk                       in   1   core clock, all state on posedge
//  rst_n                     in   1   synchronous active-low reset
//  EX_LS_reg_execute_valid   in   1   EXU presents an op
//  LS_EX_ready               out  1   lsu_wb can accept (high only in IDLE)
//  EX_LS_reg_load            in   1   op is a load
//  EX_LS_reg_store           in   1   op is a store
//  EX_LS_reg_funct3          in   3   000 B,001 H,010 W,011 D,100 BU,101 HU,110 WU
//  EX_LS_reg_rd              in   5   destination register
//  EX_LS_reg_dest_wen        in   1   op writes rd
//  EX_LS_reg_addr            in   64  effective address (load/store)
//  EX_LS_reg_result          in   64  ALU result (non-mem) / store data (store)
//  dmem_req                  out  1   bus request, held until dmem_gnt
//  dmem_wen                  out  1   1 = store
//  dmem_addr                 out  64  {addr[63:3],3'b0}
//  dmem_wdata                out  64  store data replicated to lane
//  dmem_wmask                out  8   byte strobes
//  dmem_gnt                  in   1   request accepted
//  dmem_rvalid               in   1   response (load data or store ack)
//  dmem_rdata                in   64  aligned doubleword
//  dmem_err                  in   1   bus error, qualified by dmem_rvalid
//  LS_WB_reg_ls_valid        out  1   one-cycle retire pulse to GPR
//  LS_WB_reg_trap_valid      out  1   retire carries a trap; GPR suppresses write
//  LS_WB_reg_trap_cause      out  4   4 ld-misalign,5 ld-fault,6 st-misalign,7 st-fault
//  LS_WB_reg_trap_tval       out  64  faulting address
//  LS_WB_reg_rd              out  5   rd to GPR
//  LS_WB_reg_dest_wen        out  1   write enable to GPR (0 for stores)
//  write_data                out  64  value written to rd
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - state=IDLE; every output 0 except LS_EX_ready=1.
//   - Mid-transaction reset drops dmem_req at once; a late dmem_rvalid arriving in IDLE is ignored.
//  FSM IDLE -> REQ -> WAIT -> IDLE:
//   - Accept = execute_valid & LS_EX_ready.
//   - Non-mem op: retire next cycle, ls_valid=1, write_data=result, state stays IDLE (1-cycle latency).
//   - Mem op aligned: latch op. Next cycle state=REQ with dmem_req=1.
//   - REQ: hold dmem_req and all bus fields stable until dmem_gnt, then go to WAIT.
//   - WAIT: on dmem_rvalid, retire next cycle and return to IDLE.
//     Min latency accept->retire = 3 cycles (gnt and rvalid immediate).
//   - Misaligned mem op: addr not a multiple of 2^funct3[1:0].
//     No bus request; retire next cycle with trap_valid=1, cause 4 (load) or 6 (store), tval=addr.
//   - dmem_err with rvalid: retire with trap_valid=1, cause 5 (load) or 7 (store), tval=addr, write_data=0.
//  Load data:
//   - Lane = rdata >> (8*addr[2:0]); take 8/16/32/64 bits.
//   - Sign-extend for B/H/W; zero-extend for BU/HU/WU; D taken as-is.
//  Store data:
//   - wdata = result replicated per size.
//   - wmask = {1,3,F,FF}[size] << addr[2:0].
//   - dest_wen=0.
//  Retire bundle:
//   - ls_valid is a single-cycle pulse; WB never stalls.
//   - rd and dest_wen are passed through from the latched op; a trap sets only trap_valid.
//  Illegal funct3 (111):
//   - On a load: treated as D.
//   - On a store: funct3[1:0] selects size.
//  EXU sets load and store mutually exclusive; if both are set, the op is treated as a load.
// STRUCTURE
//  - Shared package lsu_pkg:
//    - state enum (IDLE, REQ, WAIT)
//    - funct3 size/sign constants
//    - trap cause codes 4..7
//  - One sub-module, lsu_load_align (combinational extract + extend), reused by future cache path.
//  - FSM, bus registers and retire registers stay in lsu_wb.
// TESTING
//  1. LW addr=0x8000_0004, rdata=0x80000001_12345678 -> write_data=0xFFFFFFFF_80000001, wmask n/a, rd written.
//  2. LBU addr=0x8000_0003, rdata byte3=0xAB -> write_data=0x00000000_000000AB; LB same -> 0xFFFF..FFAB.
//  3. SH addr=0x1006, result=0xBEEF:
//     - dmem_wmask=0xC0, dmem_addr=0x1000, wdata lanes=0xBEEF x4
//     - retire dest_wen=0
//  4. LH addr=0x1001 -> no dmem_req; next-cycle retire with trap_valid=1, cause=4, tval=0x1001.
//  5. dmem_gnt held low 5 cycles:
//     - dmem_req and bus fields stable, LS_EX_ready=0
//     - SD then rvalid with dmem_err=1 -> cause=7, tval=addr
//  6. rst_n=0 in WAIT:
//     - next cycle all outputs 0, LS_EX_ready=1
//     - stray dmem_rvalid produces no ls_valid

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, access-size codes and trap causes for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    return sz == SZ_D ? 8'hFF : sz == SZ_W ? 8'h0F : sz == SZ_H ? 8'h03 : 8'h01;
  endfunction
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    return (3'd1 << sz) - 3'd1;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: extracts the addressed lane of a doubleword and sign/zero-extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);
  logic [63:0] lane;
  logic        sx;
  assign lane = rdata >> {offset, 3'b000};
  // funct3[2] marks the unsigned forms; 111 falls through to the full doubleword
  assign sx = ~funct3[2];
  always_comb
    data = funct3[1:0] == SZ_B ? {{56{lane[7] & sx}}, lane[7:0]} :
           funct3[1:0] == SZ_H ? {{48{lane[15] & sx}}, lane[15:0]} :
           funct3[1:0] == SZ_W ? {{32{lane[31] & sx}}, lane[31:0]} : lane;
endmodule

// File: rtl/lsu_wb.sv
// lsu_wb: load/store + writeback stage driving the single-outstanding dmem bus and the GPR write port
module lsu_wb
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_LS_reg_execute_valid,
  output logic        LS_EX_ready,
  input  logic        EX_LS_reg_load,
  input  logic        EX_LS_reg_store,
  input  logic [2:0]  EX_LS_reg_funct3,
  input  logic [4:0]  EX_LS_reg_rd,
  input  logic        EX_LS_reg_dest_wen,
  input  logic [63:0] EX_LS_reg_addr,
  input  logic [63:0] EX_LS_reg_result,
  output logic        dmem_req,
  output logic        dmem_wen,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wmask,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_err,
  output logic        LS_WB_reg_ls_valid,
  output logic        LS_WB_reg_trap_valid,
  output logic [3:0]  LS_WB_reg_trap_cause,
  output logic [63:0] LS_WB_reg_trap_tval,
  output logic [4:0]  LS_WB_reg_rd,
  output logic        LS_WB_reg_dest_wen,
  output logic [63:0] write_data
);
  state_t      state;
  logic        op_load, op_wen;
  logic [2:0]  op_funct3;
  logic [4:0]  op_rd;
  logic [63:0] op_addr, load_data, rep;
  logic [63:0] res;
  logic        accept, is_load, is_mem, misalign;
  logic [1:0]  sz;
  assign LS_EX_ready = state == IDLE;
  assign accept = EX_LS_reg_execute_valid & LS_EX_ready;
  assign is_load = EX_LS_reg_load;
  assign is_mem = EX_LS_reg_load | EX_LS_reg_store;
  assign sz = EX_LS_reg_funct3[1:0];
  assign misalign = |(EX_LS_reg_addr[2:0] & align_mask(sz));
  assign res = EX_LS_reg_result;
  assign rep = sz == SZ_D ? res : sz == SZ_W ? {2{res[31:0]}} :
               sz == SZ_H ? {4{res[15:0]}} : {8{res[7:0]}};
  lsu_load_align u_align (
    .rdata  (dmem_rdata),
    .offset (op_addr[2:0]),
    .funct3 (op_funct3),
    .data   (load_data)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      op_load              <= 1'b0;
      op_wen               <= 1'b0;
      op_funct3            <= '0;
      op_rd                <= '0;
      op_addr              <= '0;
      dmem_req             <= 1'b0;
      dmem_wen             <= 1'b0;
      dmem_addr            <= '0;
      dmem_wdata           <= '0;
      dmem_wmask           <= '0;
      LS_WB_reg_ls_valid   <= 1'b0;
      LS_WB_reg_trap_valid <= 1'b0;
      LS_WB_reg_trap_cause <= '0;
      LS_WB_reg_trap_tval  <= '0;
      LS_WB_reg_rd         <= '0;
      LS_WB_reg_dest_wen   <= 1'b0;
      write_data           <= '0;
    end else begin
      LS_WB_reg_ls_valid   <= 1'b0;
      LS_WB_reg_trap_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_load   <= is_load;
          op_wen    <= EX_LS_reg_dest_wen;
          op_funct3 <= EX_LS_reg_funct3;
          op_rd     <= EX_LS_reg_rd;
          op_addr   <= EX_LS_reg_addr;
          if (!is_mem || misalign) begin
            LS_WB_reg_ls_valid <= 1'b1;
            LS_WB_reg_rd       <= EX_LS_reg_rd;
            LS_WB_reg_dest_wen <= EX_LS_reg_dest_wen & (!is_mem || is_load);
            write_data         <= is_mem ? 64'd0 : res;
          end
          if (is_mem && misalign) begin
            LS_WB_reg_trap_valid <= 1'b1;
            LS_WB_reg_trap_cause <= is_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
            LS_WB_reg_trap_tval  <= EX_LS_reg_addr;
          end
          if (is_mem && !misalign) begin
            state      <= REQ;
            dmem_req   <= 1'b1;
            dmem_wen   <= ~is_load;
            dmem_addr  <= {EX_LS_reg_addr[63:3], 3'b000};
            dmem_wdata <= is_load ? 64'd0 : rep;
            dmem_wmask <= is_load ? 8'd0 : size_mask(sz) << EX_LS_reg_addr[2:0];
          end
        end
        REQ: if (dmem_gnt) begin
          dmem_req <= 1'b0;
          state    <= WAIT;
        end
        WAIT: if (dmem_rvalid) begin
          state                <= IDLE;
          LS_WB_reg_ls_valid   <= 1'b1;
          LS_WB_reg_trap_valid <= dmem_err;
          LS_WB_reg_rd         <= op_rd;
          LS_WB_reg_dest_wen   <= op_load & op_wen;
          write_data           <= (op_load && !dmem_err) ? load_data : 64'd0;
          if (dmem_err) begin
            LS_WB_reg_trap_cause <= op_load ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
            LS_WB_reg_trap_tval  <= op_addr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_wb.sv
// tb_lsu_wb: directed vectors with hand-computed results for lsu_wb
module tb_lsu_wb;
  logic        clk = 0, rst_n = 0;
  logic        ex_valid = 0, ex_load = 0, ex_store = 0, ex_wen = 0;
  logic [2:0]  ex_funct3 = 0;
  logic [4:0]  ex_rd = 0;
  logic [63:0] ex_addr = 0, ex_result = 0;
  logic        ready, dmem_req, dmem_wen;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        dmem_gnt = 0, dmem_rvalid = 0, dmem_err = 0;
  logic [63:0] dmem_rdata = 0;
  logic        ls_valid, trap_valid, dest_wen;
  logic [3:0]  trap_cause;
  logic [63:0] trap_tval, write_data;
  logic [4:0]  wb_rd;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  lsu_wb dut (
    .clk(clk), .rst_n(rst_n),
    .EX_LS_reg_execute_valid(ex_valid), .LS_EX_ready(ready),
    .EX_LS_reg_load(ex_load), .EX_LS_reg_store(ex_store),
    .EX_LS_reg_funct3(ex_funct3), .EX_LS_reg_rd(ex_rd),
    .EX_LS_reg_dest_wen(ex_wen), .EX_LS_reg_addr(ex_addr),
    .EX_LS_reg_result(ex_result),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
    .LS_WB_reg_ls_valid(ls_valid), .LS_WB_reg_trap_valid(trap_valid),
    .LS_WB_reg_trap_cause(trap_cause), .LS_WB_reg_trap_tval(trap_tval),
    .LS_WB_reg_rd(wb_rd), .LS_WB_reg_dest_wen(dest_wen), .write_data(write_data)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [4:0] rd,
                       input logic wen, input logic [63:0] addr, input logic [63:0] result);
    ex_valid = 1; ex_load = ld; ex_store = st; ex_funct3 = f3; ex_rd = rd;
    ex_wen = wen; ex_addr = addr; ex_result = result;
    step();
    ex_valid = 0; ex_load = 0; ex_store = 0;
  endtask
  task automatic bus_resp(input logic [63:0] rdata, input logic err);
    int n = 0;
    while (!dmem_req && n < 20) begin step(); n++; end
    chk("req_seen", dmem_req, 1'b1);
    dmem_gnt = 1; step(); dmem_gnt = 0;
    dmem_rvalid = 1; dmem_rdata = rdata; dmem_err = err; step();
    dmem_rvalid = 0; dmem_err = 0;
  endtask
  task automatic load(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] rdata,
                      input logic [63:0] exp, input string tag);
    issue(1, 0, f3, 5'd9, 1, addr, 0);
    bus_resp(rdata, 0);
    chk({tag, "_valid"}, ls_valid, 1'b1);
    chk({tag, "_data"}, write_data, exp);
  endtask
  initial begin
    repeat (2) step();
    chk("rst_ready", ready, 1'b1);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_valid", ls_valid, 1'b0);
    chk("rst_wmask", dmem_wmask, 8'h00);
    rst_n = 1;
    step();
    issue(0, 0, 3'b000, 5'd3, 1, 64'h0, 64'hDEAD_BEEF_0000_1234);
    chk("alu_valid", ls_valid, 1'b1);
    chk("alu_data", write_data, 64'hDEAD_BEEF_0000_1234);
    chk("alu_rd", wb_rd, 5'd3);
    chk("alu_ready", ready, 1'b1);
    issue(1, 0, 3'b010, 5'd5, 1, 64'h8000_0004, 0);
    chk("lw_req", dmem_req, 1'b1);
    chk("lw_addr", dmem_addr, 64'h8000_0000);
    chk("lw_wen", dmem_wen, 1'b0);
    chk("lw_ready", ready, 1'b0);
    bus_resp(64'h8000_0001_1234_5678, 0);
    chk("lw_valid", ls_valid, 1'b1);
    chk("lw_data", write_data, 64'hFFFF_FFFF_8000_0001);
    chk("lw_rd", wb_rd, 5'd5);
    chk("lw_dwen", dest_wen, 1'b1);
    chk("lw_trap", trap_valid, 1'b0);
    step();
    chk("lw_pulse", ls_valid, 1'b0);
    load(3'b100, 64'h8000_0003, 64'h0000_0000_AB00_0000, 64'h0000_0000_0000_00AB, "lbu");
    load(3'b000, 64'h8000_0003, 64'h0000_0000_AB00_0000, 64'hFFFF_FFFF_FFFF_FFAB, "lb");
    load(3'b101, 64'h0000_0006, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001, "lhu");
    load(3'b001, 64'h0000_0006, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, "lh");
    load(3'b110, 64'h0000_0004, 64'h9000_0000_0000_0000, 64'h0000_0000_9000_0000, "lwu");
    load(3'b011, 64'h0000_0008, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210, "ld");
    load(3'b111, 64'h0000_0010, 64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF, "l111");
    issue(0, 1, 3'b001, 5'd7, 1, 64'h1006, 64'h0000_0000_0000_BEEF);
    chk("sh_wmask", dmem_wmask, 8'hC0);
    chk("sh_addr", dmem_addr, 64'h1000);
    chk("sh_wdata", dmem_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
    chk("sh_wen", dmem_wen, 1'b1);
    bus_resp(0, 0);
    chk("sh_valid", ls_valid, 1'b1);
    chk("sh_dwen", dest_wen, 1'b0);
    chk("sh_trap", trap_valid, 1'b0);
    issue(0, 1, 3'b000, 5'd7, 0, 64'h2005, 64'h0000_0000_0000_005A);
    chk("sb_wmask", dmem_wmask, 8'h20);
    chk("sb_wdata", dmem_wdata, 64'h5A5A_5A5A_5A5A_5A5A);
    bus_resp(0, 0);
    issue(1, 0, 3'b001, 5'd4, 1, 64'h1001, 0);
    chk("mis_req", dmem_req, 1'b0);
    chk("mis_valid", ls_valid, 1'b1);
    chk("mis_trap", trap_valid, 1'b1);
    chk("mis_cause", trap_cause, 4'd4);
    chk("mis_tval", trap_tval, 64'h1001);
    chk("mis_ready", ready, 1'b1);
    issue(0, 1, 3'b010, 5'd4, 0, 64'h1002, 0);
    chk("smis_cause", trap_cause, 4'd6);
    chk("smis_trap", trap_valid, 1'b1);
    chk("smis_req", dmem_req, 1'b0);
    issue(0, 1, 3'b011, 5'd2, 0, 64'h2008, 64'h1122_3344_5566_7788);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", dmem_req, 1'b1);
      chk("stall_ready", ready, 1'b0);
      chk("stall_addr", dmem_addr, 64'h2008);
      chk("stall_wdata", dmem_wdata, 64'h1122_3344_5566_7788);
      chk("stall_wmask", dmem_wmask, 8'hFF);
      step();
    end
    bus_resp(0, 1);
    chk("err_valid", ls_valid, 1'b1);
    chk("err_trap", trap_valid, 1'b1);
    chk("err_cause", trap_cause, 4'd7);
    chk("err_tval", trap_tval, 64'h2008);
    chk("err_data", write_data, 64'h0);
    issue(1, 0, 3'b011, 5'd6, 1, 64'h3000, 0);
    dmem_gnt = 1; step(); dmem_gnt = 0;
    chk("wait_req", dmem_req, 1'b0);
    chk("wait_ready", ready, 1'b0);
    rst_n = 0; step();
    chk("mrst_ready", ready, 1'b1);
    chk("mrst_req", dmem_req, 1'b0);
    chk("mrst_addr", dmem_addr, 64'h0);
    chk("mrst_tval", trap_tval, 64'h0);
    chk("mrst_data", write_data, 64'h0);
    rst_n = 1;
    dmem_rvalid = 1; dmem_rdata = 64'h1234; step(); dmem_rvalid = 0;
    chk("stray_valid", ls_valid, 1'b0);
    chk("stray_ready", ready, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
